mem_arbiter: RTL

- Shares one single-port memory bus between the core's instruction-fetch port and its load/store port.
- Sits between the multicycle control unit/datapath and the unified memory. Converts level-held imem/dmem requests into bus transactions and returns one-cycle ready pulses.
- Grant is locked for the full duration of a transaction. Arbitration is round-robin when both ports request at the same time.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arb_watchdog.sv | 30 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IMEM = 1'b0,
    GRANT_DMEM = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Grant-cycle watchdog: counts ack-less grant cycles and flags the LIMIT-th one.
module mem_arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (start) begin
      count_reg <= '0;
    end else if (active && !ack) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Grant cycle N sees count N-1, so this fires in the LIMIT-th grant cycle.
  assign expired = active & ~ack & (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and load/store ports.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_read,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                bus_timeout
);

  arb_state_e state_reg;
  grant_e     last_grant_reg;

  logic dmem_req;
  logic grant_d;
  logic grant_i;
  logic start;
  logic active;
  logic timeout_hit;
  logic done;

  assign dmem_req = dmem_read | dmem_write;
  // On contention the port that did not win last time takes the bus.
  assign grant_d  = dmem_req & (~imem_read | (last_grant_reg == GRANT_IMEM));
  assign grant_i  = imem_read & ~grant_d;
  assign start    = (state_reg == IDLE) & (imem_read | dmem_req);
  assign active   = (state_reg != IDLE);

`ifdef ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .active  (active),
    .ack     (bus_ack),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0) & active;
  assign timeout_hit        = 1'b0;
`endif

  assign done        = bus_ack | timeout_hit;
  assign bus_timeout = timeout_hit;
  assign imem_ready  = (state_reg == GNT_I) & done & imem_read;
  assign dmem_ready  = (state_reg == GNT_D) & done & dmem_req;

  // A watchdog abort returns zero data because bus_ack is low in that cycle.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rdata
      assign imem_rdata[gi] = bus_rdata[gi] & imem_ready & bus_ack;
      assign dmem_rdata[gi] = bus_rdata[gi] & dmem_ready & bus_ack;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_IMEM;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_be         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            state_reg      <= GNT_D;
            last_grant_reg <= GRANT_DMEM;
            bus_req        <= 1'b1;
            bus_we         <= dmem_write;
            bus_addr       <= dmem_addr;
            bus_wdata      <= dmem_write ? dmem_wdata : '0;
            bus_be         <= dmem_write ? dmem_be : '1;
          end else if (grant_i) begin
            state_reg      <= GNT_I;
            last_grant_reg <= GRANT_IMEM;
            bus_req        <= 1'b1;
            bus_we         <= 1'b0;
            bus_addr       <= imem_addr;
            bus_wdata      <= '0;
            bus_be         <= '1;
          end
        end
        GNT_I, GNT_D: begin
          if (done) begin
            state_reg <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
